// File: rtl/u109_pci_arbiter_if.sv
// U109 PCI arbiter bus bundle: slot/host requests, sampled bus status,
// grants and ownership indications. The arbiter uses the master modport,
// the surrounding bus (slots, host, buffer control) uses the slave modport.
interface u109_pci_arbiter_if #(
    parameter int NUM_SLOTS = 5
);
    logic [NUM_SLOTS-1:0] REQn;
    logic                 HOST_REQ;
    logic                 FRAMEn;
    logic                 IRDYn;
    logic [NUM_SLOTS-1:0] GNTn;
    logic                 HOST_GNT;
    logic                 DMA_CYCLE;
    logic [2:0]           BUS_OWNER;
    logic                 ARB_TIMEOUT;

    modport master (
        input  REQn, HOST_REQ, FRAMEn, IRDYn,
        output GNTn, HOST_GNT, DMA_CYCLE, BUS_OWNER, ARB_TIMEOUT
    );

    modport slave (
        output REQn, HOST_REQ, FRAMEn, IRDYn,
        input  GNTn, HOST_GNT, DMA_CYCLE, BUS_OWNER, ARB_TIMEOUT
    );
endinterface

// File: rtl/u109_pci_arbiter.sv
// U109 central PCI arbiter. Shares the AD bus between the host side and
// NUM_SLOTS slot masters with registered grants, a one-clock turnaround
// between owners, round-robin among slots and strict host/slot alternation
// under contention. A granted slot that never starts a cycle loses its grant
// after GNT_TIMEOUT clocks.
// Optional build macro U109_HOST_PARK_EN: park the idle bus on the host.
module u109_pci_arbiter #(
    parameter int NUM_SLOTS   = 5,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                CLKP,
    input  logic                RESET,
    u109_pci_arbiter_if.master  bus
);

`ifdef U109_HOST_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    localparam int       CNT_W      = (GNT_TIMEOUT > 2) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [2:0] OWNER_HOST = 3'd6;
    localparam logic [2:0] OWNER_NONE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOST_OWN  = 3'd1,
        S_SLOT_WAIT = 3'd2,
        S_SLOT_BUSY = 3'd3,
        S_TURN      = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [2:0]           ptr_r, ptr_s;
    logic [2:0]           slot_r, slot_s;
    logic                 host_turn_r, host_turn_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [NUM_SLOTS-1:0] gntn_r, gntn_s;
    logic                 host_gnt_r, host_gnt_s;
    logic                 dma_r, dma_s;
    logic [2:0]           owner_r, owner_s;
    logic                 tmo_r, tmo_s;

    logic                 bus_idle_s;
    logic                 rr_hit_s;
    logic [2:0]           rr_idx_s;
    logic [3:0]           cand_s;
    logic [NUM_SLOTS-1:0] slot_mask_s;
    logic                 other_req_s;
    logic [2:0]           next_ptr_s;
    logic                 park_exit_s;

    assign bus_idle_s  = bus.FRAMEn & bus.IRDYn;
    assign other_req_s = |(~bus.REQn & ~slot_mask_s);
    assign next_ptr_s  = (slot_r == 3'(NUM_SLOTS - 1)) ? 3'd0 : slot_r + 3'd1;
    // Leaving a parked host grant for a slot must pass through a turnaround clock
    assign park_exit_s = PARK_EN & (state_r == S_IDLE) & host_gnt_r;

    // Round-robin search: lowest cyclic offset from the pointer wins (scan high to low)
    always_comb begin
        rr_hit_s = 1'b0;
        rr_idx_s = 3'd0;
        cand_s   = 4'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr_r} + 4'(i);
            cand_s = (cand_s >= 4'(NUM_SLOTS)) ? cand_s - 4'(NUM_SLOTS) : cand_s;
            if (!bus.REQn[cand_s[2:0]]) begin
                rr_hit_s = 1'b1;
                rr_idx_s = cand_s[2:0];
            end else begin
                rr_idx_s = rr_idx_s;
            end
        end
    end

    // One-hot mask of the slot currently holding (or last holding) the bus
    always_comb begin
        slot_mask_s         = '0;
        slot_mask_s[slot_r] = 1'b1;
    end

    // Next-state and next-output decode; outputs are registered with the state
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        slot_s      = slot_r;
        host_turn_s = host_turn_r;
        cnt_s       = cnt_r;
        gntn_s      = '1;
        host_gnt_s  = 1'b0;
        dma_s       = 1'b0;
        owner_s     = OWNER_NONE;
        tmo_s       = 1'b0;
        case (state_r)
            // TURN has already served its single dead clock, so it arbitrates like IDLE
            S_IDLE, S_TURN: begin
                state_s = S_IDLE;
                if (!bus_idle_s) begin
                    state_s = S_IDLE;
                end else if (host_turn_r && bus.HOST_REQ) begin
                    state_s    = S_HOST_OWN;
                    host_gnt_s = 1'b1;
                    owner_s    = OWNER_HOST;
                end else if (rr_hit_s && park_exit_s) begin
                    state_s = S_TURN;
                end else if (rr_hit_s) begin
                    state_s          = S_SLOT_WAIT;
                    slot_s           = rr_idx_s;
                    cnt_s            = '0;
                    gntn_s[rr_idx_s] = 1'b0;
                    owner_s          = rr_idx_s;
                end else if (bus.HOST_REQ) begin
                    state_s    = S_HOST_OWN;
                    host_gnt_s = 1'b1;
                    owner_s    = OWNER_HOST;
                end else if (PARK_EN) begin
                    host_gnt_s = 1'b1;
                    owner_s    = OWNER_HOST;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HOST_OWN: begin
                if (bus.HOST_REQ) begin
                    host_gnt_s = 1'b1;
                    owner_s    = OWNER_HOST;
                end else begin
                    host_turn_s = 1'b0;
                    state_s     = S_TURN;
                end
            end
            S_SLOT_WAIT: begin
                if (!bus.FRAMEn) begin
                    // FRAMEn beats a simultaneous timeout
                    state_s        = S_SLOT_BUSY;
                    gntn_s[slot_r] = 1'b0;
                    owner_s        = slot_r;
                    dma_s          = 1'b1;
                end else if (bus.REQn[slot_r]) begin
                    state_s = S_TURN;
                    ptr_s   = next_ptr_s;
                end else if (cnt_r == CNT_W'(GNT_TIMEOUT - 1)) begin
                    state_s = S_TURN;
                    ptr_s   = next_ptr_s;
                    tmo_s   = 1'b1;
                end else begin
                    cnt_s          = cnt_r + CNT_W'(1);
                    gntn_s[slot_r] = 1'b0;
                    owner_s        = slot_r;
                end
            end
            S_SLOT_BUSY: begin
                if (bus_idle_s) begin
                    state_s     = S_TURN;
                    ptr_s       = next_ptr_s;
                    host_turn_s = 1'b1;
                end else begin
                    dma_s   = 1'b1;
                    owner_s = slot_r;
                    // Once withdrawn the grant stays off; the master ends on its latency timer
                    if (!gntn_r[slot_r] && !bus.REQn[slot_r] && !other_req_s && !bus.HOST_REQ) begin
                        gntn_s[slot_r] = 1'b0;
                    end else begin
                        gntn_s[slot_r] = 1'b1;
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, arbitration bookkeeping and registered outputs
    always_ff @(posedge CLKP) begin
        if (RESET) begin
            state_r     <= S_IDLE;
            ptr_r       <= 3'd0;
            slot_r      <= 3'd0;
            host_turn_r <= 1'b1;
            cnt_r       <= '0;
            gntn_r      <= '1;
            host_gnt_r  <= 1'b0;
            dma_r       <= 1'b0;
            owner_r     <= OWNER_NONE;
            tmo_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            slot_r      <= slot_s;
            host_turn_r <= host_turn_s;
            cnt_r       <= cnt_s;
            gntn_r      <= gntn_s;
            host_gnt_r  <= host_gnt_s;
            dma_r       <= dma_s;
            owner_r     <= owner_s;
            tmo_r       <= tmo_s;
        end
    end

    assign bus.GNTn        = gntn_r;
    assign bus.HOST_GNT    = host_gnt_r;
    assign bus.DMA_CYCLE   = dma_r;
    assign bus.BUS_OWNER   = owner_r;
    assign bus.ARB_TIMEOUT = tmo_r;

endmodule
